// File: rtl/wmul_pkg.sv
// rtl/wmul_pkg.sv - tree depth and latency helpers shared by the multiplier and its bench
package wmul_pkg;

  localparam int ROW_LIM_N = 9;
  // Most rows that k levels of 3:2 compression can bring down to two, for k = 0..8.
  localparam logic [ROW_LIM_N-1:0][5:0] ROW_LIM = {
    6'd42, 6'd28, 6'd19, 6'd13, 6'd9, 6'd6, 6'd4, 6'd3, 6'd2
  };

  function automatic int tree_lvl(input int w);
    int lvl;
    lvl = ROW_LIM_N - 1;
    for (int i = ROW_LIM_N - 1; i >= 0; i--) begin
      if (int'(ROW_LIM[i]) >= w) lvl = i;
    end
    return lvl;
  endfunction

  function automatic int lat(input int w);
    return tree_lvl(w) + 2;
  endfunction

  // Live row count after lvls levels: each full group of three becomes two.
  function automatic int rows_after(input int w, input int lvls);
    int n;
    n = w;
    for (int k = 0; k < lvls; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

endpackage

// File: rtl/wmul_csa_row.sv
// rtl/wmul_csa_row.sv - combinational N-bit 3:2 carry-save compressor row
module wmul_csa_row #(
  parameter int W = 16,
  parameter int N = 2 * W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-1:0] maj;

  assign maj   = (a & b) | (a & c) | (b & c);
  assign sum   = a ^ b ^ c;
  assign carry = maj << 1;

endmodule

// File: rtl/wallace_mul_pipe.sv
// rtl/wallace_mul_pipe.sv - pipelined WxW Wallace multiplier, unsigned/Baugh-Wooley signed, tagged
// Optional 32-bit handshake counter port perf_cnt under WMUL_PERF_CNT_EN.
module wallace_mul_pipe
  import wmul_pkg::*;
#(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
`ifdef WMUL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cnt
`endif
);

  localparam int TREE_LVL = tree_lvl(W);
  localparam int LAT      = TREE_LVL + 2;
  localparam int P        = 2 * W;

  logic             adv;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT-1];
  logic [TAG_W-1:0] tag_d [LAT-1];
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [P-1:0]     out_p_q, out_p_d;
  logic [P-1:0]     sum_c;
  logic [P-1:0]     pp_c    [W];
  logic [P-1:0]     rows_in [TREE_LVL][W];
  logic [P-1:0]     tree_d  [TREE_LVL][W];
  logic [P-1:0]     tree_q  [TREE_LVL][W];

  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[LAT-1];
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

  // Baugh-Wooley: MSB cross terms inverted, constant 1s at columns W and 2W-1
  // tucked into the free top bits of rows 0 and W-1 so the tree sees only W rows.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      pp_c[i] = '0;
      for (int j = 0; j < W; j++) begin
        pp_c[i][i+j] = (a_q[j] & b_q[i]) ^ (sgn_q && ((i == W - 1) != (j == W - 1)));
      end
    end
    pp_c[0][W]     = sgn_q;
    pp_c[W-1][P-1] = sgn_q;
  end

  for (genvar l = 0; l < TREE_LVL; l++) begin : g_lvl
    localparam int N_IN  = rows_after(W, l);
    localparam int N_GRP = N_IN / 3;

    for (genvar r = 0; r < W; r++) begin : g_src
      if (l == 0) begin : g_pp
        assign rows_in[l][r] = pp_c[r];
      end else begin : g_reg
        assign rows_in[l][r] = tree_q[l-1][r];
      end
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
      wmul_csa_row #(.W(W), .N(P)) u_csa (
        .a     (rows_in[l][3*g]),
        .b     (rows_in[l][3*g+1]),
        .c     (rows_in[l][3*g+2]),
        .sum   (tree_d[l][2*g]),
        .carry (tree_d[l][2*g+1])
      );
    end

    // Leftover rows shift down behind the compressor outputs; slots past the end are zero.
    for (genvar j = 2 * N_GRP; j < W; j++) begin : g_pass
      if (j + N_GRP < W) begin : g_mv
        assign tree_d[l][j] = rows_in[l][j+N_GRP];
      end else begin : g_zero
        assign tree_d[l][j] = '0;
      end
    end
  end

  // Only rows 0 and 1 are live at the last level; the rest are constant zero.
  always_comb begin
    sum_c = '0;
    for (int r = 0; r < W; r++) sum_c = sum_c + tree_q[TREE_LVL-1][r];
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    vld_d     = vld_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    out_p_d   = out_p_q;
    if (adv) begin
      vld_d = {vld_q[LAT-2:0], in_valid};
      if (in_valid) begin
        a_d      = in_a;
        b_d      = in_b;
        sgn_d    = in_signed;
        tag_d[0] = in_tag;
      end
      for (int s = 1; s < LAT - 1; s++) begin
        if (vld_q[s-1]) tag_d[s] = tag_q[s-1];
      end
      if (vld_q[LAT-2]) begin
        out_p_d   = sum_c;
        out_tag_d = tag_q[LAT-2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else begin
      vld_q     <= vld_d;
      out_p_q   <= out_p_d;
      out_tag_q <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
    tag_q <= tag_d;
    if (adv) tree_q <= tree_d;
  end

`ifdef WMUL_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q + ((out_valid && out_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
- Parametrised, fully pipelined W×W multiplier with valid/ready flow control.
- Supports unsigned and two's-complement signed operands, selectable per transaction.
- Carries a sideband tag through the pipeline.
- Products are generated with partial-product AND rows (Baugh-Wooley for signed), a registered 3:2 carry-save tree, and a registered final carry-propagate adder.
- Drop-in successor for the fixed 16-bit multiplier in the ALU execute path.

Parameters:
- W, 16: operand width; legal 4..32.
- TAG_W, 4: sideband tag width; legal 1..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  in  TAG_W  sideband; returned unchanged with the product.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2W  full product.
- out_tag  out  TAG_W  tag of this product.

Behaviour:
- Tree depth: TREE_LVL is the number of 3:2 levels needed to reduce W rows to 2.
  - Row-limit sequence: 2, 3, 4, 6, 9, 13, 19, 28, 42.
  - TREE_LVL = index of the first entry ≥ W, counting the entry 2 as index 0.
  - Examples: W=8 → 4, W=16 → 6, W=32 → 8.
- Latency: LAT = TREE_LVL + 2 cycles from an accepted input to out_valid (16-bit: 8).
  - Stage 0: registered operands, mode and tag.
  - Stages 1..TREE_LVL: one registered CSA level each.
  - Final stage: registered 2W-bit carry-propagate add.
- Pipeline control:
  - Every stage holds a valid bit, cleared on reset.
  - Global advance enable adv = !(out_valid && !out_ready).
  - When adv=0, every stage register, including its valid bit, holds.
  - in_ready = adv, combinational from out_valid/out_ready only.
  - A beat is accepted when in_valid && in_ready.
  - Stage-0 valid loads in_valid && in_ready whenever adv=1.
  - Bubbles are not collapsed; throughput is 1 product/cycle when out_ready stays high.
- Arithmetic:
  - Unsigned: out_p = in_a*in_b, exact in 2W bits.
  - Signed: out_p = two's-complement product in 2W bits.
  - Signed uses Baugh-Wooley: invert the MSB cross terms and add constant 1s at columns W and 2W-1.
  - Any carry out of bit 2W-1 is discarded; the result is still exact.
  - Signed boundary: (-2^(W-1)) × (-2^(W-1)) = 2^(2W-2), which must be exact.
- Mode and tag travel with their beat. Mixing signed and unsigned beats back-to-back is legal.
- Reset values: out_valid=0, out_p=0, out_tag=0, all stage valids 0. Data registers need not reset.
- Reset mid-operation: all in-flight beats are lost and no out_valid is produced for them. in_ready=1 from the first cycle after rst_n rises.
- Stalls:
  - out_valid && !out_ready holds out_p/out_tag stable for as long as the stall lasts.
  - A beat presented during a stall is not accepted and must be re-presented.
- X hygiene: in_a/in_b/in_tag are ignored when in_valid=0. Data of an invalid stage never reaches out_p while out_valid=1.

Optional Feature:
- Macro WMUL_PERF_CNT_EN.
- Defined:
  - Adds output port perf_cnt, 32 bits.
  - Reset 0.
  - Increments by 1 on each cycle with out_valid && out_ready.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wmul_pkg:
  - function tree_lvl(W) implementing the row-limit sequence.
  - function lat(W) = tree_lvl(W) + 2.
  - localparam for the row-limit table.
  - The bench imports lat() to compute expected latency.
- Sub-module wmul_csa_row:
  - Parameter N (default 2W).
  - Combinational 3:2 compressor: sum = a^b^c; carry = majority(a,b,c) shifted left by 1, truncated to N.
  - Instantiated per level; registers stay in the top level.

Test Plan:
- Unsigned, W=16, out_ready=1: a=0xFFFF, b=0xFFFF, signed=0, tag=3 → out_p=0xFFFE0001, out_tag=3, exactly 8 cycles after acceptance.
- Signed boundary, W=16: a=0x8000, b=0x8000, signed=1 → 0x40000000. Next beat a=0xFFFF, b=0x0002, signed=1 → 0xFFFFFFFE. Both products appear on consecutive cycles.
- Back-to-back stream of 100 random mixed-mode beats with out_ready=1:
  - Every product matches the reference model.
  - Tags appear in order.
  - One output per cycle after an 8-cycle fill.
- Backpressure:
  - Drop out_ready for 5 cycles while out_valid=1 → out_p/out_tag stable, in_ready=0, no beats lost or duplicated.
  - Raise out_ready → stream resumes in order.
- Reset mid-stream: assert rst_n=0 with 4 beats in flight →
  - out_valid=0 and out_p=0 asynchronously.
  - After release, none of the 4 beats emerge.
  - in_ready=1.
- Parameter sweep: W=8 (LAT=6) and W=32 (LAT=10) with exhaustive or corner operands (0, 1, max, min signed). With WMUL_PERF_CNT_EN defined, perf_cnt equals the handshake count after 1000 beats.
